// File: rtl/key_scan_pkg.sv
// Shared defaults and FSM state type for the key scan controller.
package key_scan_pkg;

   localparam int unsigned DEF_N_KEYS         = 4;
   localparam int unsigned DEF_STABLE_CYCLES  = 5;
   localparam int unsigned DEF_RELEASE_CYCLES = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILTER = 2'd1,
      S_HELD   = 2'd2
   } state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw active-low key lines; resets to released.
module key_sync
   import key_scan_pkg::*;
#(
   parameter int unsigned N_KEYS = DEF_N_KEYS
)(
   input  logic              clk,
   input  logic              rst_p,
   input  logic [N_KEYS-1:0] i_keys_n,
   output logic [N_KEYS-1:0] o_keys_n
);

   logic [N_KEYS-1:0] r_meta;
   logic [N_KEYS-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst_p) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_keys_n;
         r_sync <= r_meta;
      end
   end

   assign o_keys_n = r_sync;

endmodule

// File: rtl/key_scan_ctrl.sv
// Shared-filter key scanner: round-robin grant, press debounce, release debounce.
module key_scan_ctrl
   import key_scan_pkg::*;
#(
   parameter  int unsigned N_KEYS         = DEF_N_KEYS,
   parameter  int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter  int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES,
   localparam int unsigned CODE_W         = $clog2(N_KEYS)
)(
   input  logic              clk,
   input  logic              rst_p,
   input  logic [N_KEYS-1:0] keys_n,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_code,
   output logic              key_held,
   output logic              key_release,
   output logic              busy
);

   localparam int unsigned CNT_MAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES
                                                                      : RELEASE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t             r_state;
   logic [CODE_W-1:0]  r_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic [CODE_W-1:0]  r_code;
   logic               r_valid;
   logic               r_held;
   logic               r_release;
   logic               r_busy;

   state_t             w_state_nxt;
   logic [CODE_W-1:0]  w_ptr_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CODE_W-1:0]  w_code_nxt;
   logic               w_valid_nxt;
   logic               w_held_nxt;
   logic               w_release_nxt;
   logic [N_KEYS-1:0]  w_keys_s;
   logic               w_gnt_found;
   logic [CODE_W-1:0]  w_gnt_idx;
   logic               w_gnt_lvl;
   logic [CODE_W-1:0]  w_code_inc;

   key_sync #(
      .N_KEYS (N_KEYS)
   ) u_sync (
      .clk      (clk),
      .rst_p    (rst_p),
      .i_keys_n (keys_n),
      .o_keys_n (w_keys_s)
   );

   assign w_gnt_lvl  = w_keys_s[r_code];
   assign w_code_inc = (32'(r_code) == N_KEYS - 1) ? '0 : r_code + CODE_W'(1);

   // Round-robin search: first low line at or after r_ptr, wrapping at N_KEYS.
   always_comb begin
      int unsigned v_cand;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      v_cand      = 0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         v_cand = 32'(r_ptr) + i;
         if (v_cand >= N_KEYS) begin
            v_cand = v_cand - N_KEYS;
         end
         if (!w_gnt_found && !w_keys_s[v_cand[CODE_W-1:0]]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = v_cand[CODE_W-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_code_nxt    = r_code;
      w_valid_nxt   = 1'b0;
      w_held_nxt    = r_held;
      w_release_nxt = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_held_nxt = 1'b0;
            if (w_gnt_found) begin
               w_code_nxt  = w_gnt_idx;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = S_FILTER;
            end
         end
         S_FILTER: begin
            if (!w_gnt_lvl) begin
               if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                  w_cnt_nxt   = '0;
                  w_valid_nxt = 1'b1;
                  w_held_nxt  = 1'b1;
                  w_state_nxt = S_HELD;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end else begin
               w_cnt_nxt   = '0;
               w_ptr_nxt   = w_code_inc;
               w_state_nxt = S_IDLE;
            end
         end
         S_HELD: begin
            if (w_gnt_lvl) begin
               if (r_cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
                  w_cnt_nxt     = '0;
                  w_release_nxt = 1'b1;
                  w_held_nxt    = 1'b0;
                  w_ptr_nxt     = w_code_inc;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end else begin
               w_cnt_nxt = '0;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_held_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_code    <= '0;
         r_valid   <= 1'b0;
         r_held    <= 1'b0;
         r_release <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_code    <= w_code_nxt;
         r_valid   <= w_valid_nxt;
         r_held    <= w_held_nxt;
         r_release <= w_release_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign key_valid   = r_valid;
   assign key_code    = r_code;
   assign key_held    = r_held;
   assign key_release = r_release;
   assign busy        = r_busy;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed and randomized checks of key_scan_ctrl against a sample-history model.
module tb_key_scan_ctrl;

   localparam int NK = 4;
   localparam int SC = 5;
   localparam int RC = 5;

   logic          clk = 1'b0;
   logic          rst_p = 1'b1;
   logic [NK-1:0] keys_n = '1;
   logic          key_valid;
   logic [1:0]    key_code;
   logic          key_held;
   logic          key_release;
   logic          busy;

   key_scan_ctrl #(
      .N_KEYS         (NK),
      .STABLE_CYCLES  (SC),
      .RELEASE_CYCLES (RC)
   ) dut (
      .clk         (clk),
      .rst_p       (rst_p),
      .keys_n      (keys_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_held    (key_held),
      .key_release (key_release),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference: granted key (-1 = none), run length of the current phase
   logic [NK-1:0] m_s1, m_s2;
   int   m_gnt, m_run, m_ptr, m_code;
   bit   m_conf;
   bit   e_valid, e_rel;

   int   edge_no, sc_valid, sc_rel, sc_vedge, sc_redge;
   bit   saw_busy;
   int   sc_codes[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [NK-1:0] k, input logic r);
      logic [NK-1:0] smp;
      int c;
      e_valid = 1'b0;
      e_rel   = 1'b0;
      if (r) begin
         m_s1 = '1; m_s2 = '1;
         m_gnt = -1; m_run = 0; m_ptr = 0; m_code = 0; m_conf = 1'b0;
         return;
      end
      smp = m_s2;
      if (m_gnt < 0) begin
         for (int j = 0; j < NK; j++) begin
            c = (m_ptr + j) % NK;
            if (m_gnt < 0 && !smp[c]) begin
               m_gnt = c; m_code = c; m_run = 1; m_conf = 1'b0;
            end
         end
      end else if (!m_conf) begin
         if (!smp[m_gnt]) begin
            m_run++;
            if (m_run == SC) begin
               m_conf = 1'b1; m_run = 0; e_valid = 1'b1;
            end
         end else begin
            m_ptr = (m_gnt + 1) % NK; m_gnt = -1; m_run = 0;
         end
      end else begin
         if (smp[m_gnt]) begin
            m_run++;
            if (m_run == RC) begin
               e_rel = 1'b1; m_ptr = (m_gnt + 1) % NK;
               m_gnt = -1; m_run = 0; m_conf = 1'b0;
            end
         end else begin
            m_run = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = k;
   endtask

   task automatic clear_sc();
      edge_no = 0; sc_valid = 0; sc_rel = 0;
      sc_vedge = -1; sc_redge = -1; saw_busy = 1'b0;
      sc_codes.delete();
   endtask

   task automatic step(input logic [NK-1:0] k, input logic r);
      keys_n = k;
      rst_p  = r;
      @(posedge clk);
      model(k, r);
      #1;
      chk("key_valid", 32'(key_valid), 32'(e_valid));
      chk("key_release", 32'(key_release), 32'(e_rel));
      chk("key_held", 32'(key_held), 32'(m_gnt >= 0 && m_conf));
      chk("busy", 32'(busy), 32'(m_gnt >= 0));
      chk("key_code", 32'(key_code), 32'(m_code));
      chk("ptr", 32'(dut.r_ptr), 32'(m_ptr));
      chk("valid_release_excl", 32'(key_valid & key_release), 32'd0);
      if (key_valid) begin
         sc_valid++;
         sc_codes.push_back(int'(key_code));
         if (sc_vedge < 0) sc_vedge = edge_no;
      end
      if (key_release) begin
         sc_rel++;
         if (sc_redge < 0) sc_redge = edge_no;
      end
      if (busy) saw_busy = 1'b1;
      edge_no++;
   endtask

   task automatic run(input logic [NK-1:0] k, input int n);
      for (int i = 0; i < n; i++) step(k, 1'b0);
   endtask

   initial begin
      logic [NK-1:0] pat;
      int dur;

      // reset state
      step('1, 1'b1);
      step('1, 1'b1);
      chk("reset_outputs", {key_valid, key_held, key_release, busy, key_code}, 32'd0);

      // single press of key 2: valid at edge 6, then release
      clear_sc();
      run(4'b1011, 10);
      chk("press_latency_edge", sc_vedge, 6);
      chk("press_valid_count", sc_valid, 1);
      chk("press_code", sc_codes.size() > 0 ? sc_codes[0] : -1, 2);
      chk("press_held", 32'(key_held), 32'd1);
      run(4'b1111, 10);
      chk("press_release_count", sc_rel, 1);

      // short glitch on key 2: no press, back to idle with ptr 3
      step('1, 1'b1);
      clear_sc();
      run(4'b1011, 3);
      run(4'b1111, 6);
      chk("glitch_no_valid", sc_valid, 0);
      chk("glitch_saw_busy", 32'(saw_busy), 32'd1);
      chk("glitch_busy_end", 32'(busy), 32'd0);
      chk("glitch_ptr", 32'(dut.r_ptr), 32'd3);

      // keys 1 and 3 together: key 1 first, then key 3 after key 1 releases
      step('1, 1'b1);
      clear_sc();
      run(4'b0101, 10);
      run(4'b0111, 20);
      chk("rr_valid_count", sc_valid, 2);
      chk("rr_first_code", sc_codes.size() > 0 ? sc_codes[0] : -1, 1);
      chk("rr_second_code", sc_codes.size() > 1 ? sc_codes[1] : -1, 3);
      chk("rr_release_count", sc_rel, 1);
      run(4'b1111, 10);

      // release bounce on key 0: single release after fifth consecutive high
      step('1, 1'b1);
      clear_sc();
      run(4'b1110, 10);
      run(4'b1111, 3);
      run(4'b1110, 1);
      chk("bounce_no_early_release", sc_rel, 0);
      edge_no = 0;
      run(4'b1111, 8);
      chk("bounce_release_count", sc_rel, 1);
      chk("bounce_release_edge", sc_redge, 6);

      // reset while held
      step('1, 1'b1);
      clear_sc();
      run(4'b1110, 10);
      chk("abort_held_before", 32'(key_held), 32'd1);
      step(4'b1110, 1'b1);
      chk("abort_outputs", {key_valid, key_held, key_release, busy, key_code}, 32'd0);
      chk("abort_ptr", 32'(dut.r_ptr), 32'd0);
      run(4'b1111, 8);
      chk("abort_no_release", sc_rel, 0);

      // randomized segments against the model
      for (int s = 0; s < 60; s++) begin
         pat = 4'($urandom) | 4'($urandom);
         dur = $urandom_range(1, 14);
         if ($urandom_range(0, 24) == 0) step(pat, 1'b1);
         run(pat, dur);
      end
      run(4'b1111, 12);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
